// File: rtl/wb_gateway_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_gateway_arbiter
// Round-robin N:1 Wishbone arbiter, grant locked per CYC, boot-locked to
// master 0 until config_done. Optional watchdog: define WB_GW_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module wb_gateway_arbiter #(
  parameter int NUM_M  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int TO_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     config_done,
  input  logic [NUM_M-1:0]         s_cyc,
  input  logic [NUM_M-1:0]         s_stb,
  input  logic [NUM_M-1:0]         s_we,
  input  logic [NUM_M*ADDR_W-1:0]  s_adr,
  input  logic [NUM_M*DATA_W-1:0]  s_dat_w,
  input  logic [NUM_M*SEL_W-1:0]   s_sel,
  output logic [DATA_W-1:0]        s_dat_r,
  output logic [NUM_M-1:0]         s_ack,
  output logic [NUM_M-1:0]         s_err,
  output logic                     m_cyc,
  output logic                     m_stb,
  output logic                     m_we,
  output logic [ADDR_W-1:0]        m_adr,
  output logic [DATA_W-1:0]        m_dat_w,
  output logic [SEL_W-1:0]         m_sel,
  input  logic [DATA_W-1:0]        m_dat_r,
  input  logic                     m_ack,
  input  logic                     m_err,
  output logic [NUM_M-1:0]         gnt
);

  localparam int PTR_W = $clog2(NUM_M);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  if (NUM_M < 2 || NUM_M > 8) begin : g_bad_num_m
    $error("wb_gateway_arbiter: NUM_M must be 2..8");
  end
  if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to_cyc
    $error("wb_gateway_arbiter: TO_CYC must be 1..65535");
  end

  state_t             state_q, state_d;
  logic [NUM_M-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_M-1:0]   w_mask;
  logic [NUM_M-1:0]   w_elig;
  logic               w_found;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_cyc;
  logic               w_stb;
  logic               w_we;
  logic [ADDR_W-1:0]  w_adr;
  logic [DATA_W-1:0]  w_dat_w;
  logic [SEL_W-1:0]   w_sel;
  logic               w_to_hit;

  // Until configuration completes only master 0 may compete.
  assign w_mask = config_done ? {NUM_M{1'b1}} : {{(NUM_M-1){1'b0}}, 1'b1};
  assign w_elig = s_cyc & w_mask;

  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!w_found && w_elig[idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[PTR_W-1:0];
      end
    end
  end

  // One-hot grant mux; all-zero when nobody owns the bus.
  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    w_we    = 1'b0;
    w_adr   = '0;
    w_dat_w = '0;
    w_sel   = '0;
    w_gidx  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_q[i]) begin
        w_cyc   = s_cyc[i];
        w_stb   = s_stb[i];
        w_we    = s_we[i];
        w_adr   = s_adr[i*ADDR_W +: ADDR_W];
        w_dat_w = s_dat_w[i*DATA_W +: DATA_W];
        w_sel   = s_sel[i*SEL_W +: SEL_W];
        w_gidx  = PTR_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PTR_W'(NUM_M - 1)) ? '0 : w_gidx + 1'b1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          gnt_d   = {{(NUM_M-1){1'b0}}, 1'b1} << w_pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!w_cyc) begin
          gnt_d    = '0;
          rr_ptr_d = w_ptr_nxt;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef WB_GW_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;

  // Restart on every slave response; a firing also restarts the window.
  always_comb begin
    timer_d = timer_q;
    if (state_q != ST_BUSY || m_ack || m_err || w_to_hit) begin
      timer_d = '0;
    end else if (w_stb) begin
      timer_d = timer_q + 16'd1;
    end
  end

  assign w_to_hit = (state_q == ST_BUSY) && (timer_q == 16'(TO_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign w_to_hit = 1'b0;
`endif

  assign m_cyc   = w_cyc;
  assign m_stb   = w_stb & ~w_to_hit;
  assign m_we    = w_we;
  assign m_adr   = w_adr;
  assign m_dat_w = w_dat_w;
  assign m_sel   = w_sel;
  assign s_dat_r = m_dat_r;
  // ERR dominates ACK when the slave raises both.
  assign s_ack   = gnt_q & {NUM_M{m_ack & ~m_err & ~w_to_hit}};
  assign s_err   = gnt_q & {NUM_M{m_err | w_to_hit}};
  assign gnt     = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_gateway_arbiter.sv
`default_nettype none
// Testbench for wb_gateway_arbiter: directed stimulus, scoreboard-checked
// slave responses plus direct grant/mux checks.
module tb_wb_gateway_arbiter;

  localparam int NUM_M  = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int TO_CYC = 8;
`ifdef WB_GW_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic                     config_done;
  logic [NUM_M-1:0]         s_cyc, s_stb, s_we;
  logic [NUM_M*ADDR_W-1:0]  s_adr;
  logic [NUM_M*DATA_W-1:0]  s_dat_w;
  logic [NUM_M*SEL_W-1:0]   s_sel;
  logic [DATA_W-1:0]        s_dat_r;
  logic [NUM_M-1:0]         s_ack, s_err;
  logic                     m_cyc, m_stb, m_we;
  logic [ADDR_W-1:0]        m_adr;
  logic [DATA_W-1:0]        m_dat_w;
  logic [SEL_W-1:0]         m_sel;
  logic [DATA_W-1:0]        m_dat_r;
  logic                     m_ack, m_err;
  logic [NUM_M-1:0]         gnt;

  wb_gateway_arbiter #(
    .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .config_done(config_done),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
    .s_ack(s_ack), .s_err(s_err),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r),
    .m_ack(m_ack), .m_err(m_err), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_M-1:0] ack;
    logic [NUM_M-1:0] err;
    logic             chk_dat;
    logic [31:0]      dat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   ack1_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [NUM_M-1:0] ack, input logic [NUM_M-1:0] err,
                      input logic chk, input logic [31:0] dat);
    exp_t e;
    e.ack = ack; e.err = err; e.chk_dat = chk; e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic drv(input int i, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    s_cyc[i] = cyc;
    s_stb[i] = stb;
    s_we[i]  = we;
    s_adr[i*ADDR_W +: ADDR_W]   = adr;
    s_dat_w[i*DATA_W +: DATA_W] = dat;
    s_sel[i*SEL_W +: SEL_W]     = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every ACK/ERR the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (s_ack[1]) ack1_cnt++;
    if ((|s_ack) || (|s_err)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected: ack=%b err=%b with nothing expected", s_ack, s_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (s_ack !== e.ack || s_err !== e.err || (e.chk_dat && s_dat_r !== e.dat)) begin
          n_fails++;
          $display("FAIL sb_resp: got ack=%b err=%b dat=0x%0h, expected ack=%b err=%b dat=0x%0h",
                   s_ack, s_err, s_dat_r, e.ack, e.err, e.dat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NUM_M-1:0] exp_g;
    logic             exp_e;
    int               base;
    int               n_cyc;

    rst = 1'b1; config_done = 1'b0;
    s_cyc = '1; s_stb = '0; s_we = '0; s_adr = '0; s_dat_w = '0; s_sel = '0;
    m_dat_r = '0; m_ack = 1'b0; m_err = 1'b0;

    // Reset: requests present but nothing may be granted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_m_cyc", m_cyc, 0);
    check("rst_m_stb", m_stb, 0);
    check("rst_m_adr", m_adr, 0);
    check("rst_s_ack", s_ack, 0);
    s_cyc = '0;
    rst = 1'b0;

    // Boot lock: m0 and m1 request, only m0 served.
    drv(0, 1, 1, 0, 32'h10, 32'h0, 4'hF);
    drv(1, 1, 1, 1, 32'h20, 32'hA5A5_0001, 4'h3);
    tick();
    check("t1_gnt_m0", gnt, 3'b001);
    check("t1_m_adr", m_adr, 32'h10);
    check("t1_m_we", m_we, 0);
    m_dat_r = 32'h11;
    push(3'b001, 3'b000, 1'b1, 32'h11);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    drv(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("t1_idle", gnt, 0);
    m_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t1_locked", gnt, 0);
      check("t1_stray_ack", s_ack, 0);
    end
    m_ack = 1'b0;
    config_done = 1'b1;
    tick();
    check("t1_unlock_gnt", gnt, 3'b010);
    check("t1_m_we", m_we, 1);
    check("t1_m_dat_w", m_dat_w, 32'hA5A5_0001);
    check("t1_m_sel", m_sel, 4'h3);
    push(3'b010, 3'b000, 1'b0, 32'h0);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    drv(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("t1_release", gnt, 0);

    // Reset pointer, then three simultaneous requesters.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_M; i++) drv(i, 1, 1, 0, 32'h100 + i, 32'h0, 4'hF);
    for (int k = 0; k < NUM_M; k++) begin
      tick();
      exp_g = 3'b001 << k;
      check("t2_grant", gnt, exp_g);
      check("t2_m_adr", m_adr, 32'h100 + k);
      push(exp_g, 3'b000, 1'b0, 32'h0);
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      drv(k, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      tick();
      check("t2_idle_gap", gnt, 0);
    end

    // Four-beat burst by m1 under one CYC.
    drv(1, 1, 1, 1, 32'h200, 32'hBEEF, 4'hF);
    tick();
    check("t3_gnt", gnt, 3'b010);
    base = ack1_cnt;
    for (int b = 0; b < 4; b++) begin
      push(3'b010, 3'b000, 1'b0, 32'h0);
      m_ack = 1'b1;
      tick();
      check("t3_hold", gnt, 3'b010);
    end
    m_ack = 1'b0;
    drv(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("t3_release", gnt, 0);
    check("t3_ack_pulses", ack1_cnt - base, 4);

    // Read by m2 (pointer now past m1).
    drv(2, 1, 1, 0, 32'h14, 32'h0, 4'hF);
    tick();
    check("t4_gnt", gnt, 3'b100);
    check("t4_m_adr", m_adr, 32'h14);
    check("t4_m_stb", m_stb, 1);
    check("t4_m_we", m_we, 0);
    m_dat_r = 32'h60;
    push(3'b100, 3'b000, 1'b1, 32'h60);
    m_ack = 1'b1;
    #1;
    check("t4_rdata", s_dat_r, 32'h60);
    check("t4_ack_same_clk", s_ack, 3'b100);
    tick();
    m_ack = 1'b0;
    drv(2, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("t4_release", gnt, 0);

    // ACK+ERR together, then reset mid-transfer.
    drv(0, 1, 1, 1, 32'h30, 32'h1234, 4'hF);
    tick();
    check("t5_gnt", gnt, 3'b001);
    push(3'b000, 3'b001, 1'b0, 32'h0);
    m_ack = 1'b1;
    m_err = 1'b1;
    #1;
    check("t5_err", s_err, 3'b001);
    check("t5_no_ack", s_ack, 3'b000);
    tick();
    m_err = 1'b0;
    check("t5_busy_cyc", m_cyc, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_cyc", m_cyc, 0);
    check("t5_rst_gnt", gnt, 0);
    check("t5_rst_stb", m_stb, 0);
    check("t5_rst_adr", m_adr, 0);
    check("t5_rst_ack", s_ack, 0);
    tick();
    m_ack = 1'b0;
    rst = 1'b0;
    drv(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // config_done falls while m1 owns the bus: cycle completes, mask then applies.
    drv(1, 1, 1, 0, 32'h50, 32'h0, 4'hF);
    tick();
    check("t5_cfg_gnt", gnt, 3'b010);
    config_done = 1'b0;
    push(3'b010, 3'b000, 1'b0, 32'h0);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    check("t5_cfg_hold", gnt, 3'b010);
    drv(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    drv(1, 1, 1, 0, 32'h50, 32'h0, 4'hF);
    tick();
    check("t5_cfg_mask", gnt, 0);
    drv(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    config_done = 1'b1;
    tick();

    // Hung slave: watchdog fires exactly TO_CYC clocks after STB when enabled.
    drv(0, 1, 1, 0, 32'h40, 32'h0, 4'hF);
    tick();
    check("t6_gnt", gnt, 3'b001);
    n_cyc = TO_EN ? 12 : 100;
    for (int c = 0; c < n_cyc; c++) begin
      exp_e = TO_EN && (c == TO_CYC);
      if (exp_e) push(3'b000, 3'b001, 1'b0, 32'h0);
      #1;
      check("t6_s_err", s_err[0], exp_e);
      check("t6_m_stb", m_stb, !exp_e);
      check("t6_gnt_kept", gnt, 3'b001);
      tick();
    end
    drv(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("t6_release", gnt, 0);

    tick();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
